// File: rtl/butterfly_pkg.sv
// butterfly_pkg
// Shared definitions for the pipelined radix-2 butterfly:
//   - mode encodings (DIT / DIF)
//   - width-generic rounding, saturation and scaled add/sub helpers that work
//     on a wide signed carrier; callers size-cast the result back to N bits
//   - per-stage control payload that travels alongside the data registers
package butterfly_pkg;

    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;

    // Wide enough for a full 2N+1-bit product plus rounding headroom at N=64.
    localparam int WIDE_W = 132;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Control that rides with each stage's data words.
    typedef struct packed {
        logic mode;
        logic scale;
        logic ovf;
    } stage_ctrl_t;

    // Round half up, then arithmetic shift right by sh.
    function automatic wide_t round_shift(input wide_t x, input int sh);
        wide_t r;
        if (sh > 0) r = (x + (wide_t'(1) <<< (sh - 1))) >>> sh;
        else        r = x;
        return r;
    endfunction

    // Clamp to the signed range of a w-bit word; hit flags a clamp.
    function automatic wide_t saturate(input wide_t x, input int w, output logic hit);
        wide_t hi;
        wide_t lo;
        wide_t r;
        hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (w - 1));
        hit = 1'b0;
        r   = x;
        if (x > hi) begin
            r   = hi;
            hit = 1'b1;
        end else if (x < lo) begin
            r   = lo;
            hit = 1'b1;
        end
        return r;
    endfunction

    // a +/- b, optionally halved with round-half-up, saturated to w bits.
    function automatic wide_t add_sub(input wide_t a, input wide_t b, input logic sub,
                                      input logic halve, input int w, output logic hit);
        wide_t s;
        s = sub ? (a - b) : (a + b);
        if (halve) s = (s + wide_t'(1)) >>> 1;
        return saturate(s, w, hit);
    endfunction

endpackage

// File: rtl/cmult_pipe.sv
// cmult_pipe
// Two-stage complex multiplier for the butterfly datapath.
//   S2: registers the four raw partial products xr*wr, xc*wc, xr*wc, xc*wr.
//   S3: combines, rounds (half up at bit D-1), shifts by D, saturates to N
//       bits and registers the result together with a saturation flag.
// Ports:
//   clk, reset (async active-low), en (global pipeline advance)
//   x_r, x_c  multiplicand        w_r, w_c  twiddle
//   p_r, p_c  registered product  sat       clamp occurred on either part
module cmult_pipe
    import butterfly_pkg::*;
#(
    parameter int N = 32,
    parameter int D = 16
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] x_r,
    input  logic [N-1:0] x_c,
    input  logic [N-1:0] w_r,
    input  logic [N-1:0] w_c,
    output logic [N-1:0] p_r,
    output logic [N-1:0] p_c,
    output logic         sat
);

    logic signed [2*N-1:0] rr_d, rr_q, cc_d, cc_q, rc_d, rc_q, cr_d, cr_q;
    logic [N-1:0]          pr_d, pr_q, pc_d, pc_q;
    logic                  sat_d, sat_q;
    logic                  hit_r, hit_c;

    always_comb begin
        rr_d  = rr_q;
        cc_d  = cc_q;
        rc_d  = rc_q;
        cr_d  = cr_q;
        pr_d  = pr_q;
        pc_d  = pc_q;
        sat_d = sat_q;
        hit_r = 1'b0;
        hit_c = 1'b0;
        if (en) begin
            rr_d  = (2*N)'($signed(x_r)) * (2*N)'($signed(w_r));
            cc_d  = (2*N)'($signed(x_c)) * (2*N)'($signed(w_c));
            rc_d  = (2*N)'($signed(x_r)) * (2*N)'($signed(w_c));
            cr_d  = (2*N)'($signed(x_c)) * (2*N)'($signed(w_r));
            pr_d  = N'(saturate(round_shift(wide_t'(rr_q) - wide_t'(cc_q), D), N, hit_r));
            pc_d  = N'(saturate(round_shift(wide_t'(rc_q) + wide_t'(cr_q), D), N, hit_c));
            sat_d = hit_r | hit_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q  <= '0;
            cc_q  <= '0;
            rc_q  <= '0;
            cr_q  <= '0;
            pr_q  <= '0;
            pc_q  <= '0;
            sat_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            cc_q  <= cc_d;
            rc_q  <= rc_d;
            cr_q  <= cr_d;
            pr_q  <= pr_d;
            pc_q  <= pc_d;
            sat_q <= sat_d;
        end
    end

    assign p_r = pr_q;
    assign p_c = pc_q;
    assign sat = sat_q;

endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe
// Fully pipelined radix-2 complex butterfly, one transaction per cycle,
// latency 3 from the accepting edge to send_val.
//   S1: register operands; in DIF mode compute s = a+b, t = a-b here.
//   S2/S3: complex multiply of the selected operand by w (cmult_pipe), or a
//          two-register bypass when MULT=0.
//   OUT: DIT add/sub of a with the product, output registers.
// A single enable stalls every stage while the output is held.
// Ports:
//   clk, reset (async active-low)
//   recv_val/recv_rdy, ar/ac/br/bc/wr/wc, mode, scale   input side
//   send_val/send_rdy, cr/cc/dr/dc, ovf                  output side
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int N    = 32,
    parameter int D    = 16,
    parameter int MULT = 1
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [N-1:0] ar,
    input  logic [N-1:0] ac,
    input  logic [N-1:0] br,
    input  logic [N-1:0] bc,
    input  logic [N-1:0] wr,
    input  logic [N-1:0] wc,
    input  logic         mode,
    input  logic         scale,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [N-1:0] cr,
    output logic [N-1:0] cc,
    output logic [N-1:0] dr,
    output logic [N-1:0] dc,
    output logic         ovf
);

    logic en;

    // Stage 1
    logic              s1_val_d, s1_val_q;
    logic [N-1:0]      s1_ar_d, s1_ar_q, s1_ac_d, s1_ac_q;
    logic [N-1:0]      s1_xr_d, s1_xr_q, s1_xc_d, s1_xc_q;
    logic [N-1:0]      s1_wr_d, s1_wr_q, s1_wc_d, s1_wc_q;
    stage_ctrl_t       s1_ctrl_d, s1_ctrl_q;
    logic [N-1:0]      s_r, s_c, t_r, t_c;
    logic              hit_sr, hit_sc, hit_tr, hit_tc;

    // Stages 2 and 3 (the a-path and control; products live in cmult_pipe)
    logic              s2_val_d, s2_val_q, s3_val_d, s3_val_q;
    logic [N-1:0]      s2_ar_d, s2_ar_q, s2_ac_d, s2_ac_q;
    logic [N-1:0]      s3_ar_d, s3_ar_q, s3_ac_d, s3_ac_q;
    stage_ctrl_t       s2_ctrl_d, s2_ctrl_q, s3_ctrl_d, s3_ctrl_q;

    // Product at the stage-3 boundary
    logic [N-1:0]      p_r, p_c;
    logic              p_sat;

    // Output stage
    logic              send_val_d, send_val_q, ovf_d, ovf_q;
    logic [N-1:0]      cr_d, cr_q, cc_d, cc_q, dr_d, dr_q, dc_d, dc_q;
    logic [N-1:0]      c_r, c_c, d_r, d_c;
    logic              hit_cr, hit_cc, hit_dr, hit_dc;

    assign en       = !send_val_q || send_rdy;
    assign recv_rdy = reset && en;

    always_comb begin
        hit_sr = 1'b0;
        hit_sc = 1'b0;
        hit_tr = 1'b0;
        hit_tc = 1'b0;
        s_r = N'(add_sub(wide_t'($signed(ar)), wide_t'($signed(br)), 1'b0, scale, N, hit_sr));
        s_c = N'(add_sub(wide_t'($signed(ac)), wide_t'($signed(bc)), 1'b0, scale, N, hit_sc));
        t_r = N'(add_sub(wide_t'($signed(ar)), wide_t'($signed(br)), 1'b1, scale, N, hit_tr));
        t_c = N'(add_sub(wide_t'($signed(ac)), wide_t'($signed(bc)), 1'b1, scale, N, hit_tc));

        s1_val_d  = s1_val_q;
        s1_ar_d   = s1_ar_q;
        s1_ac_d   = s1_ac_q;
        s1_xr_d   = s1_xr_q;
        s1_xc_d   = s1_xc_q;
        s1_wr_d   = s1_wr_q;
        s1_wc_d   = s1_wc_q;
        s1_ctrl_d = s1_ctrl_q;
        if (en) begin
            s1_val_d        = recv_val && recv_rdy;
            s1_wr_d         = wr;
            s1_wc_d         = wc;
            s1_ctrl_d.mode  = mode;
            s1_ctrl_d.scale = scale;
            if (mode == MODE_DIF) begin
                // The multiplier then sees t; s rides the a-path as c.
                s1_ar_d       = s_r;
                s1_ac_d       = s_c;
                s1_xr_d       = t_r;
                s1_xc_d       = t_c;
                s1_ctrl_d.ovf = hit_sr | hit_sc | hit_tr | hit_tc;
            end else begin
                s1_ar_d       = ar;
                s1_ac_d       = ac;
                s1_xr_d       = br;
                s1_xc_d       = bc;
                s1_ctrl_d.ovf = 1'b0;
            end
        end
    end

    always_comb begin
        s2_val_d  = s2_val_q;
        s2_ar_d   = s2_ar_q;
        s2_ac_d   = s2_ac_q;
        s2_ctrl_d = s2_ctrl_q;
        s3_val_d  = s3_val_q;
        s3_ar_d   = s3_ar_q;
        s3_ac_d   = s3_ac_q;
        s3_ctrl_d = s3_ctrl_q;
        if (en) begin
            s2_val_d  = s1_val_q;
            s2_ar_d   = s1_ar_q;
            s2_ac_d   = s1_ac_q;
            s2_ctrl_d = s1_ctrl_q;
            s3_val_d  = s2_val_q;
            s3_ar_d   = s2_ar_q;
            s3_ac_d   = s2_ac_q;
            s3_ctrl_d = s2_ctrl_q;
        end
    end

    generate
        if (MULT != 0) begin : g_mult
            cmult_pipe #(.N(N), .D(D)) u_cmult (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .x_r   (s1_xr_q),
                .x_c   (s1_xc_q),
                .w_r   (s1_wr_q),
                .w_c   (s1_wc_q),
                .p_r   (p_r),
                .p_c   (p_c),
                .sat   (p_sat)
            );
        end else begin : g_bypass
            // Two registers keep the same latency as the multiplier path.
            logic [N-1:0] s2_xr_d, s2_xr_q, s2_xc_d, s2_xc_q;
            logic [N-1:0] s3_xr_d, s3_xr_q, s3_xc_d, s3_xc_q;

            always_comb begin
                s2_xr_d = s2_xr_q;
                s2_xc_d = s2_xc_q;
                s3_xr_d = s3_xr_q;
                s3_xc_d = s3_xc_q;
                if (en) begin
                    s2_xr_d = s1_xr_q;
                    s2_xc_d = s1_xc_q;
                    s3_xr_d = s2_xr_q;
                    s3_xc_d = s2_xc_q;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s2_xr_q <= '0;
                    s2_xc_q <= '0;
                    s3_xr_q <= '0;
                    s3_xc_q <= '0;
                end else begin
                    s2_xr_q <= s2_xr_d;
                    s2_xc_q <= s2_xc_d;
                    s3_xr_q <= s3_xr_d;
                    s3_xc_q <= s3_xc_d;
                end
            end

            assign p_r   = s3_xr_q;
            assign p_c   = s3_xc_q;
            assign p_sat = 1'b0;
        end
    endgenerate

    always_comb begin
        hit_cr = 1'b0;
        hit_cc = 1'b0;
        hit_dr = 1'b0;
        hit_dc = 1'b0;
        c_r    = s3_ar_q;
        c_c    = s3_ac_q;
        d_r    = p_r;
        d_c    = p_c;
        if (s3_ctrl_q.mode == MODE_DIT) begin
            c_r = N'(add_sub(wide_t'($signed(s3_ar_q)), wide_t'($signed(p_r)), 1'b0,
                             s3_ctrl_q.scale, N, hit_cr));
            c_c = N'(add_sub(wide_t'($signed(s3_ac_q)), wide_t'($signed(p_c)), 1'b0,
                             s3_ctrl_q.scale, N, hit_cc));
            d_r = N'(add_sub(wide_t'($signed(s3_ar_q)), wide_t'($signed(p_r)), 1'b1,
                             s3_ctrl_q.scale, N, hit_dr));
            d_c = N'(add_sub(wide_t'($signed(s3_ac_q)), wide_t'($signed(p_c)), 1'b1,
                             s3_ctrl_q.scale, N, hit_dc));
        end

        send_val_d = send_val_q;
        cr_d       = cr_q;
        cc_d       = cc_q;
        dr_d       = dr_q;
        dc_d       = dc_q;
        ovf_d      = ovf_q;
        if (en) begin
            send_val_d = s3_val_q;
            cr_d       = c_r;
            cc_d       = c_c;
            dr_d       = d_r;
            dc_d       = d_c;
            ovf_d      = s3_ctrl_q.ovf | p_sat | hit_cr | hit_cc | hit_dr | hit_dc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_val_q   <= 1'b0;
            s1_ar_q    <= '0;
            s1_ac_q    <= '0;
            s1_xr_q    <= '0;
            s1_xc_q    <= '0;
            s1_wr_q    <= '0;
            s1_wc_q    <= '0;
            s1_ctrl_q  <= '0;
            s2_val_q   <= 1'b0;
            s2_ar_q    <= '0;
            s2_ac_q    <= '0;
            s2_ctrl_q  <= '0;
            s3_val_q   <= 1'b0;
            s3_ar_q    <= '0;
            s3_ac_q    <= '0;
            s3_ctrl_q  <= '0;
            send_val_q <= 1'b0;
            cr_q       <= '0;
            cc_q       <= '0;
            dr_q       <= '0;
            dc_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_val_q   <= s1_val_d;
            s1_ar_q    <= s1_ar_d;
            s1_ac_q    <= s1_ac_d;
            s1_xr_q    <= s1_xr_d;
            s1_xc_q    <= s1_xc_d;
            s1_wr_q    <= s1_wr_d;
            s1_wc_q    <= s1_wc_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s2_val_q   <= s2_val_d;
            s2_ar_q    <= s2_ar_d;
            s2_ac_q    <= s2_ac_d;
            s2_ctrl_q  <= s2_ctrl_d;
            s3_val_q   <= s3_val_d;
            s3_ar_q    <= s3_ar_d;
            s3_ac_q    <= s3_ac_d;
            s3_ctrl_q  <= s3_ctrl_d;
            send_val_q <= send_val_d;
            cr_q       <= cr_d;
            cc_q       <= cc_d;
            dr_q       <= dr_d;
            dc_q       <= dc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign send_val = send_val_q;
    assign cr       = cr_q;
    assign cc       = cc_q;
    assign dr       = dr_q;
    assign dc       = dc_q;
    assign ovf      = ovf_q;

endmodule
